// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 initiator, MSB first, full-duplex single-word transfers
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active-high
//   start    one-cycle transfer request, honoured only while idle
//   tx_data  word to send, captured when start is accepted
//   rx_data  last received word, updated when done pulses
//   busy     high from the cycle after start is accepted until done
//   done     one-cycle pulse at end of transfer
//   sclk     SPI clock, idles low
//   mosi     serial data out
//   miso     serial data in, already synchronous to clk
//   cs_n     chip select, active-low
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, FIN} state_t;

  state_t                state, state_nxt;
  logic [DIV_W-1:0]      div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] tx_sr, tx_sr_nxt;
  logic [DATA_WIDTH-1:0] rx_sr, rx_sr_nxt;
  logic [DATA_WIDTH-1:0] rx_data_nxt;
  logic                  busy_nxt, done_nxt, sclk_nxt, mosi_nxt, cs_n_nxt;
  logic                  div_end;

  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_sr   <= tx_sr_nxt;
      rx_sr   <= rx_sr_nxt;
      rx_data <= rx_data_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      cs_n    <= cs_n_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    tx_sr_nxt   = tx_sr;
    rx_sr_nxt   = rx_sr;
    rx_data_nxt = rx_data;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    sclk_nxt    = sclk;
    mosi_nxt    = mosi;
    cs_n_nxt    = cs_n;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SETUP;
          // MSB goes straight onto mosi; the shifter holds the remaining bits.
          mosi_nxt    = tx_data[DATA_WIDTH-1];
          tx_sr_nxt   = {tx_data[DATA_WIDTH-2:0], 1'b0};
          rx_sr_nxt   = '0;
          bit_cnt_nxt = '0;
          div_cnt_nxt = '0;
          cs_n_nxt    = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      SETUP, LOW: begin
        if (!div_end) begin
          div_cnt_nxt = div_cnt + 1'b1;
        end else begin
          div_cnt_nxt = '0;
          if (state == LOW && bit_cnt == BIT_LAST) begin
            state_nxt = HOLD;
          end else begin
            // Rising sclk edge: miso is captured on the same clk edge.
            state_nxt   = HIGH;
            sclk_nxt    = 1'b1;
            rx_sr_nxt   = {rx_sr[DATA_WIDTH-2:0], miso};
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      HIGH: begin
        if (!div_end) begin
          div_cnt_nxt = div_cnt + 1'b1;
        end else begin
          div_cnt_nxt = '0;
          state_nxt   = LOW;
          sclk_nxt    = 1'b0;
          // After the final bit mosi keeps its value through HOLD.
          if (bit_cnt != BIT_LAST) begin
            mosi_nxt  = tx_sr[DATA_WIDTH-1];
            tx_sr_nxt = {tx_sr[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (!div_end) begin
          div_cnt_nxt = div_cnt + 1'b1;
        end else begin
          div_cnt_nxt = '0;
          state_nxt   = FIN;
          cs_n_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          mosi_nxt    = 1'b0;
          rx_data_nxt = rx_sr;
        end
      end
      FIN: begin
        // start is not looked at here, guaranteeing a second cs_n-high cycle.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

  localparam int LOW_CYC = 2 * (2 * 8 + 2);

  logic       clk = 1'b0;
  logic       rst;
  logic       start, miso, busy, done, sclk, mosi, cs_n;
  logic [7:0] tx_data, rx_data;
  logic       start1, busy1, done1, sclk1, mosi1, cs_n1;
  logic [7:0] tx1, rx1;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .rx_data(rx1),
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1), .cs_n(cs_n1)
  );

  // miso source: 0 loopback, 1 tied high, 2 tied low, 3 slave model
  int         mode = 0;
  logic [7:0] sl_word = 8'h00;
  logic [7:0] sl_cap = 8'h00;
  int         fall_cnt = 0;
  int         fall_base = 0;
  logic       sl_bit;

  always @(negedge sclk) fall_cnt++;
  always @(negedge cs_n) fall_base = fall_cnt;
  always @(posedge sclk) sl_cap = {sl_cap[6:0], mosi};

  assign sl_bit = ((fall_cnt - fall_base) < 8) ? sl_word[3'(7 - (fall_cnt - fall_base))] : 1'b0;
  assign miso = (mode == 0) ? mosi : (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : sl_bit;

  int tests = 0;
  int fails = 0;
  logic [7:0] hold_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_rx(input int md, input logic [7:0] tx, input logic [7:0] sw);
    case (md)
      0: return tx;
      1: return 8'hFF;
      2: return 8'h00;
      default: return sw;
    endcase
  endfunction

  task automatic xfer(input string tag, input logic [7:0] tx, input int md, input logic [7:0] sw,
                      input logic [7:0] erx, input bit chk_cap, input bit mid_start, input int rst_rise);
    int cyc, rises, cs_low, dones, done_cyc, first_rise, busy_bad, rx_bad, abort_cyc;
    logic [7:0] mosi_seen, cur_hold;
    logic prev_sclk;
    bit aborted;
    rises = 0; cs_low = 0; dones = 0; done_cyc = 0; first_rise = 0;
    busy_bad = 0; rx_bad = 0; abort_cyc = 0; mosi_seen = 8'h00;
    prev_sclk = 1'b0; aborted = 1'b0; cur_hold = hold_rx;
    mode = md;
    sl_word = sw;
    @(negedge clk);
    tx_data = tx;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= LOW_CYC + 3) begin
      if (!cs_n) cs_low++;
      if (sclk && !prev_sclk) begin
        rises++;
        mosi_seen = {mosi_seen[6:0], mosi};
        if (rises == 1) first_rise = cyc;
      end
      prev_sclk = sclk;
      if (done) begin
        dones++;
        done_cyc = cyc;
        cur_hold = erx;
      end else if (rx_data !== cur_hold) begin
        rx_bad++;
      end
      if (!aborted && busy !== (cyc <= LOW_CYC)) busy_bad++;
      if (mid_start && cyc == 10) begin
        start = 1'b1;
        tx_data = 8'h11;
      end else if (mid_start && cyc == 11) begin
        start = 1'b0;
      end
      if (rst_rise > 0 && rises == rst_rise && !aborted) begin
        rst = 1'b1;
        #1;
        check({tag, "_rst_cs_n"}, cs_n, 1'b1);
        check({tag, "_rst_sclk"}, sclk, 1'b0);
        check({tag, "_rst_busy"}, busy, 1'b0);
        check({tag, "_rst_rx"}, rx_data, 8'h00);
        check({tag, "_rst_done"}, done, 1'b0);
        aborted = 1'b1;
        abort_cyc = cyc;
        cur_hold = 8'h00;
      end
      if (aborted && cyc == abort_cyc + 2) rst = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (aborted) begin
      check({tag, "_abort_dones"}, dones, 0);
      check({tag, "_abort_rx_stable"}, rx_bad, 0);
      hold_rx = 8'h00;
    end else begin
      check({tag, "_dones"}, dones, 1);
      check({tag, "_done_cyc"}, done_cyc, LOW_CYC + 1);
      check({tag, "_cs_low"}, cs_low, LOW_CYC);
      check({tag, "_rises"}, rises, 8);
      check({tag, "_first_rise"}, first_rise, 3);
      check({tag, "_mosi_bits"}, mosi_seen, tx);
      check({tag, "_rx_data"}, rx_data, erx);
      check({tag, "_busy"}, busy_bad, 0);
      check({tag, "_rx_stable"}, rx_bad, 0);
      check({tag, "_mosi_idle"}, mosi, 1'b0);
      if (chk_cap) check({tag, "_slave_cap"}, sl_cap, tx);
      hold_rx = erx;
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    int         md;
    logic [7:0] sw;
    logic [7:0] erx;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{8'hA5, 0, 8'h00, 8'hA5};
    vt[1] = '{8'h3C, 3, 8'hC3, 8'hC3};
    vt[2] = '{8'h5A, 1, 8'h00, 8'hFF};
    vt[3] = '{8'h5A, 2, 8'h00, 8'h00};

    rst = 1'b1; start = 1'b0; tx_data = 8'h00; start1 = 1'b0; tx1 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_cs_n", cs_n, 1'b1);
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rx", rx_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      xfer($sformatf("vec%0d", i), vt[i].tx, vt[i].md, vt[i].sw, vt[i].erx, vt[i].md == 3, 1'b0, 0);

    xfer("mid_start", 8'hE7, 0, 8'h00, 8'hE7, 1'b0, 1'b1, 0);
    xfer("abort", 8'h5A, 0, 8'h00, 8'h5A, 1'b0, 1'b0, 4);
    xfer("after_abort", 8'h5A, 0, 8'h00, 8'h5A, 1'b0, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] rtx, rsw;
      int rmd;
      rtx = 8'($urandom);
      rsw = 8'($urandom);
      rmd = $urandom_range(0, 3);
      xfer($sformatf("rand%0d", i), rtx, rmd, rsw, ref_rx(rmd, rtx, rsw), rmd == 3, 1'b0, 0);
    end

    begin
      int cyc, run, gap, ntr, r, last_rise, d, period_bad;
      logic ps, pc;
      run = 0; gap = 0; ntr = 0; r = 0; last_rise = 0; d = 0; period_bad = 0;
      ps = 1'b0; pc = 1'b1;
      @(negedge clk);
      tx1 = 8'h96;
      start1 = 1'b1;
      for (cyc = 0; cyc < 100; cyc++) begin
        @(negedge clk);
        if (!cs_n1) begin
          if (pc) begin
            if (ntr > 0) check($sformatf("div1_gap%0d", ntr), gap, 2);
            run = 0;
            r = 0;
            ntr++;
          end
          run++;
        end else begin
          if (!pc) begin
            check($sformatf("div1_cs_low%0d", ntr), run, 18);
            check($sformatf("div1_rises%0d", ntr), r, 8);
            gap = 0;
          end
          gap++;
        end
        pc = cs_n1;
        if (sclk1 && !ps) begin
          r++;
          if (r > 1 && cyc - last_rise != 2) period_bad++;
          last_rise = cyc;
        end
        ps = sclk1;
        if (done1) begin
          d++;
          check($sformatf("div1_rx%0d", d), rx1, 8'h96);
          if (d == 3) start1 = 1'b0;
        end
        if (d == 3 && gap > 6) break;
      end
      check("div1_dones", d, 3);
      check("div1_transfers", ntr, 3);
      check("div1_sclk_period", period_bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
